multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multicycle control unit for the 32-bit ARM-subset CPU, successor to the single-cycle instruction decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and owns the NZCV flag register and condition-code check. It drives every datapath strobe, and stalls on a memory ready handshake. It sits between the instruction register and the shared multicycle datapath (PC, IR, register file, ALU, unified memory).

## Interface
Parameters:
- `ALUCTRL_W`, 3: ALUControl width. Minimum 3.
- `MEM_HANDSHAKE`, 1: 1 means FETCH/MEMRD/MEMWR wait for `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.

Ports:
- `clk` in 1: the single clock. Reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous, active-low reset.
- `Cond` in 4: Instr[31:28].
- `Op` in 2: Instr[27:26].
- `Funct` in 6: Instr[25:20].
- `Rd` in 4: Instr[15:12].
- `ALUFlags` in 4: NZCV from the ALU, current cycle.
- `mem_ready` in 1: the memory access completes this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: write strobes.
- `AdrSrc`, `ALUSrcA` out 1 each: memory address mux (0 = PC) and ALU A mux (1 = PC).
- `ALUSrcB`, `ResultSrc` out 2 each: ALUSrcB 00 reg, 01 imm, 10 const 4. ResultSrc 00 ALUOut, 01 ReadData, 10 ALU direct.
- `ImmSrc`, `RegSrc` out 2 each: equal to `Op` and `{Op==10, Op==01}`.
- `ALUControl` out ALUCTRL_W: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MOV (pass B).
- `Flags` out 4: registered NZCV.
- `illegal` out 1: one-cycle pulse in DECODE for Op=11 or an unimplemented DP Funct.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Reset state is FETCH.
- **FETCH:** AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=`mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE:** computes PC+8 (same mux settings as FETCH, no strobes). Latches `cond_ex` = CondCheck(`Cond`, `Flags`).
  - If `cond_ex`=0, or Op=11, or the DP Funct is unimplemented: go to FETCH.
  - Otherwise: Op=01 goes to MEMADR; Op=00 goes to EXECR/EXECI by Funct[5]; Op=10 goes to BRANCH.
- **DP Funct[4:1] decode:** 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP.
  - CMP uses SUB, forces flag update, and does no writeback.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 goes to MEMRD, otherwise to MEMWR.
- **MEMRD:** AdrSrc=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWR:** AdrSrc=1, MemWrite=1. Holds MemWrite until `mem_ready`, then goes to FETCH.
- **MEMWB:** ResultSrc=01, RegWrite=1, PCWrite=(Rd==15). Goes to FETCH.
- **EXECR/EXECI:** ALUSrcA=0, ALUSrcB=00/01, ALUControl from the decode.
  - Flag update is registered at the end of the cycle when Funct[0]=1 or CMP.
  - N and Z always update. C and V update only for ADD/SUB/CMP.
  - Next state: ALUWB, or FETCH for CMP.
- **ALUWB:** ResultSrc=00, RegWrite=1, PCWrite=(Rd==15). Goes to FETCH.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Goes to FETCH.
- **CondCheck:** implements all ARM codes 0000–1110 (EQ..AL). 1111 is treated as fail.
- **Unlisted outputs:** 0 in every state. ALUControl is ADD outside EXEC states.

## Timing
- Moore outputs, except the FETCH strobes, which are gated by `mem_ready`.
- Cycle counts with `mem_ready` tied high:
  - DP: 4 cycles (3 for CMP).
  - LDR: 5. STR: 4. B: 3.
  - Condition-failed or illegal instruction: 2.
- Each wait cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
- `Flags` changes only on the clk edge leaving EXECR/EXECI. The DECODE check uses the pre-update value.
- **While `reset_n` is low:**
  - state is FETCH, `Flags` is 0000, `cond_ex` is 0.
  - All strobes (PCWrite, IRWrite, RegWrite, MemWrite) are forced 0; `illegal` is 0.
- Reset deassertion mid-instruction restarts at FETCH. No partial write may complete after reset is asserted.

## Structure
- **`ctrl_pkg`:** state enum, ALUControl codes, ResultSrc/ALUSrcB codes, condition-code constants.
- **Sub-module `cond_unit`:** NZCV register, flag-write gating, CondCheck. It is instantiated once.

## Test plan
- **Reset mid-MEMWR:** assert `reset_n`=0 during MEMWR → MemWrite drops asynchronously. After release: state FETCH, Flags=0000.
- **SUBS R1,R2,#5 with result 0, mem_ready high:** 4 cycles. Flags=0110 after EXECI. RegWrite pulses only in ALUWB.
- **BEQ with Z=0:** DECODE goes to FETCH in 2 cycles with no PCWrite in DECODE. With Z=1: BRANCH asserts PCWrite, 3 cycles total.
- **LDR R15 with mem_ready low for 3 cycles in MEMRD:** 8 cycles total. MEMWB asserts RegWrite=1 and PCWrite=1.
- **CMP, then Op=11:** CMP updates flags with no RegWrite. Op=11 pulses `illegal` for 1 cycle and returns to FETCH.
- **MEM_HANDSHAKE=0 with mem_ready held 0:** LDR still completes in 5 cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, datapath mux codes,
// ALU operation codes and the ARM condition-code check.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv = {N, Z, C, V}; the 1111 encoding never executes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_check = z;
            COND_NE: cond_check = !z;
            COND_CS: cond_check = c;
            COND_CC: cond_check = !c;
            COND_MI: cond_check = n;
            COND_PL: cond_check = !n;
            COND_VS: cond_check = v;
            COND_VC: cond_check = !v;
            COND_HI: cond_check = c && !z;
            COND_LS: cond_check = !c || z;
            COND_GE: cond_check = (n == v);
            COND_LT: cond_check = (n != v);
            COND_GT: cond_check = !z && (n == v);
            COND_LE: cond_check = z || (n != v);
            COND_AL: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with per-field write gating, plus the condition check and the
// condition-passed bit captured in DECODE for the rest of the instruction.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic       flag_wr_nz,
    input  logic       flag_wr_cv,
    output logic [3:0] flags,
    output logic       cond_pass
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    always_comb begin
        cond_pass = cond_check(cond, flags_q);
        cond_ex_d = cond_latch ? cond_pass : cond_ex_q;
        flags_d   = flags_q;
        if (flag_wr_nz && cond_ex_q) flags_d[3:2] = alu_flags[3:2];
        if (flag_wr_cv && cond_ex_q) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the ARM-subset CPU: sequences fetch/decode/execute/memory/
// writeback, drives every datapath strobe and mux select, and stalls on mem_ready.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 3,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic                 illegal
);

    state_t     state_q, state_d;
    logic       mem_ok, cond_pass, cond_latch, wr_nz, wr_cv;
    logic       pc_w, ir_w, reg_w, mem_w, ill;
    logic [2:0] alu_sel, dp_alu;
    logic       dp_legal, is_cmp, is_arith;

    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        dp_alu   = ALU_ADD;
        dp_legal = 1'b1;
        is_cmp   = 1'b0;
        is_arith = 1'b0;
        case (Funct[4:1])
            4'b0100: begin dp_alu = ALU_ADD; is_arith = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; is_arith = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: dp_alu = ALU_EOR;
            4'b1101: dp_alu = ALU_MOV;
            4'b1010: begin dp_alu = ALU_SUB; is_arith = 1'b1; is_cmp = 1'b1; end
            default: dp_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ill        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        alu_sel    = ALU_ADD;
        cond_latch = 1'b0;
        wr_nz      = 1'b0;
        wr_cv      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                ir_w      = mem_ok;
                pc_w      = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                cond_latch = 1'b1;
                ill        = (Op == OP_ILL) || ((Op == OP_DP) && !dp_legal);
                if (!cond_pass || ill)   state_d = S_FETCH;
                else if (Op == OP_MEM)   state_d = S_MEMADR;
                else if (Op == OP_DP)    state_d = Funct[5] ? S_EXECI : S_EXECR;
                else                     state_d = S_BRANCH;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                reg_w     = 1'b1;
                pc_w      = (Rd == 4'd15);
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                alu_sel = dp_alu;
                // CMP always sets flags; only arithmetic ops touch C and V
                wr_nz   = Funct[0] || is_cmp;
                wr_cv   = (Funct[0] || is_cmp) && is_arith;
                state_d = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                pc_w    = (Rd == 4'd15);
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pc_w      = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    cond_unit u_cond (
        .clk        (clk),
        .reset_n    (reset_n),
        .cond       (Cond),
        .alu_flags  (ALUFlags),
        .cond_latch (cond_latch),
        .flag_wr_nz (wr_nz),
        .flag_wr_cv (wr_cv),
        .flags      (Flags),
        .cond_pass  (cond_pass)
    );

    // Strobes are masked by reset_n so no write can land while reset is held
    assign PCWrite    = pc_w  && reset_n;
    assign IRWrite    = ir_w  && reset_n;
    assign RegWrite   = reg_w && reset_n;
    assign MemWrite   = mem_w && reset_n;
    assign illegal    = ill   && reset_n;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_BR, Op == OP_MEM};
    assign ALUControl = ALUCTRL_W'(alu_sel);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues expected strobe events and
// snapshots per cycle; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n, rst2_n;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       done;

    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    logic       b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_AdrSrc, b_ALUSrcA, b_illegal;
    logic [1:0] b_ALUSrcB, b_ResultSrc, b_ImmSrc, b_RegSrc;
    logic [2:0] b_ALUControl;
    logic [3:0] b_Flags;

    int cyc = 0;
    int base;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        bit          snap;
        bit          d2;
        logic [4:0]  strb;   // {PCWrite, IRWrite, RegWrite, MemWrite, illegal}
        logic [5:0]  mux;    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
        logic [3:0]  flags;
        logic [63:0] nm;
    } item_t;

    item_t sb[$];

    localparam logic [5:0] MX_FETCH = 6'b0_1_10_10;
    localparam logic [5:0] MX_ALUWB = 6'b0_0_00_00;
    localparam logic [5:0] MX_MEMWB = 6'b0_0_00_01;
    localparam logic [5:0] MX_MEM   = 6'b1_0_00_00;
    localparam logic [5:0] MX_BR    = 6'b0_0_01_10;

    multicycle_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset_n(reset_n), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd),
        .ALUFlags(alu_flags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags),
        .illegal(illegal)
    );

    multicycle_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(0)) dut_nohs (
        .clk(clk), .reset_n(rst2_n), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd),
        .ALUFlags(alu_flags), .mem_ready(1'b0),
        .PCWrite(b_PCWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
        .AdrSrc(b_AdrSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ResultSrc(b_ResultSrc),
        .ImmSrc(b_ImmSrc), .RegSrc(b_RegSrc), .ALUControl(b_ALUControl), .Flags(b_Flags),
        .illegal(b_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(input logic [63:0] nm, input int k, input logic [4:0] s,
                      input logic [5:0] m, input logic [3:0] f);
        item_t it;
        it.cyc = base + k; it.snap = 1'b0; it.d2 = 1'b0;
        it.strb = s; it.mux = m; it.flags = f; it.nm = nm;
        sb.push_back(it);
    endtask

    task automatic snap(input logic [63:0] nm, input int abs_cyc, input bit d2,
                        input logic [4:0] s, input logic [5:0] m, input logic [3:0] f);
        item_t it;
        it.cyc = abs_cyc; it.snap = 1'b1; it.d2 = d2;
        it.strb = s; it.mux = m; it.flags = f; it.nm = nm;
        sb.push_back(it);
    endtask

    task automatic fe(input logic [63:0] nm, input logic [3:0] f);
        ev(nm, 0, 5'b11000, MX_FETCH, f);
    endtask

    task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af, input logic [15:0] mask,
                       input int n);
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        for (int k = 0; k < n; k++) begin
            mem_ready = mask[k];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every observed strobe, and every scheduled snapshot, consumes one item
    always @(negedge clk) begin
        item_t       e;
        logic [4:0]  as;
        logic [5:0]  am;
        logic [3:0]  af;
        logic [1:0]  ai, ar;
        logic [2:0]  ac;
        logic [1:0]  op_now;
        op_now = op;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expected at cycle %0d, not seen (now %0d)", e.nm, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc && (sb[0].snap || (reset_n && |{PCWrite, IRWrite, RegWrite, MemWrite, illegal}))) begin
            e = sb.pop_front();
            if (e.d2) begin
                as = {b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_illegal};
                am = {b_AdrSrc, b_ALUSrcA, b_ALUSrcB, b_ResultSrc};
                af = b_Flags; ai = b_ImmSrc; ar = b_RegSrc; ac = b_ALUControl;
            end else begin
                as = {PCWrite, IRWrite, RegWrite, MemWrite, illegal};
                am = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
                af = Flags; ai = ImmSrc; ar = RegSrc; ac = ALUControl;
            end
            checks++;
            if (as !== e.strb || am !== e.mux || af !== e.flags || ai !== op_now ||
                ar !== {op_now == 2'b10, op_now == 2'b01} || ac !== 3'd0) begin
                failures++;
                $display("FAIL %s cyc=%0d: strb=%b mux=%b flags=%b imm=%b reg=%b alu=%0d, expected strb=%b mux=%b flags=%b imm=%b reg=%b alu=0",
                         e.nm, cyc, as, am, af, ai, ar, ac, e.strb, e.mux, e.flags,
                         op_now, {op_now == 2'b10, op_now == 2'b01});
            end
        end else if (reset_n === 1'b1 && |{PCWrite, IRWrite, RegWrite, MemWrite, illegal}) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe cyc=%0d: strb=%b, expected none", cyc,
                     {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        done = 1'b0;
        reset_n = 1'b0; rst2_n = 1'b0;
        cond = 4'b1110; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
        mem_ready = 1'b1;
        snap("rst1", 2, 1'b0, 5'b00000, MX_FETCH, 4'b0000);
        snap("rst2", 3, 1'b1, 5'b00000, MX_FETCH, 4'b0000);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;

        // SUBS R1,R2,#5 -> zero result with carry
        base = cyc; fe("f_subs", 4'b0000);
        ev("subs_wb", 3, 5'b00100, MX_ALUWB, 4'b0110);
        run(4'b1110, 2'b00, 6'b100101, 4'd1, 4'b0110, 16'hFFFF, 4);

        // BEQ taken (Z=1)
        base = cyc; fe("f_beq1", 4'b0110);
        ev("beq_br", 2, 5'b10000, MX_BR, 4'b0110);
        run(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 16'hFFFF, 3);

        // ADDS clears all flags
        base = cyc; fe("f_adds", 4'b0110);
        ev("adds_wb", 3, 5'b00100, MX_ALUWB, 4'b0000);
        run(4'b1110, 2'b00, 6'b101001, 4'd3, 4'b0000, 16'hFFFF, 4);

        // BEQ not taken (Z=0): two cycles, no PCWrite
        base = cyc; fe("f_beq0", 4'b0000);
        run(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 16'hFFFF, 2);

        // LDR R15 with three MEMRD wait cycles
        base = cyc; fe("f_ldr", 4'b0000);
        ev("ldr_wb", 7, 5'b10100, MX_MEMWB, 4'b0000);
        run(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 16'hFFC7, 8);

        // STR with one FETCH wait cycle
        base = cyc;
        ev("f_str", 1, 5'b11000, MX_FETCH, 4'b0000);
        ev("str_mw", 4, 5'b00010, MX_MEM, 4'b0000);
        run(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000, 16'hFFFE, 5);

        // CMP without S bit still sets NZCV
        base = cyc; fe("f_cmp", 4'b0000);
        run(4'b1110, 2'b00, 6'b110100, 4'd0, 4'b1001, 16'hFFFF, 3);

        // Op=11 illegal
        base = cyc; fe("f_op11", 4'b1001);
        ev("ill_op11", 1, 5'b00001, MX_FETCH, 4'b1001);
        run(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, 16'hFFFF, 2);

        // ANDS updates N,Z only
        base = cyc; fe("f_ands", 4'b1001);
        ev("ands_wb", 3, 5'b00100, MX_ALUWB, 4'b0001);
        run(4'b1110, 2'b00, 6'b000001, 4'd2, 4'b0011, 16'hFFFF, 4);

        // ADDLT R15 passes with N!=V, writes PC, leaves flags
        base = cyc; fe("f_addlt", 4'b0001);
        ev("addlt_wb", 3, 5'b10100, MX_ALUWB, 4'b0001);
        run(4'b1011, 2'b00, 6'b101000, 4'd15, 4'b1111, 16'hFFFF, 4);

        // ADDGE fails
        base = cyc; fe("f_addge", 4'b0001);
        run(4'b1010, 2'b00, 6'b101000, 4'd4, 4'b0000, 16'hFFFF, 2);

        // Unimplemented DP funct
        base = cyc; fe("f_unimp", 4'b0001);
        ev("ill_dp", 1, 5'b00001, MX_FETCH, 4'b0001);
        run(4'b1110, 2'b00, 6'b001110, 4'd0, 4'b0000, 16'hFFFF, 2);

        // STR stalled in MEMWR, then reset asserted mid-cycle
        base = cyc; fe("f_strrst", 4'b0001);
        ev("rst_mw", 3, 5'b00010, MX_MEM, 4'b0001);
        snap("rst_async", base + 4, 1'b0, 5'b00000, MX_FETCH, 4'b0000);
        run(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000, 16'h0007, 4);
        mem_ready = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Restart from FETCH with cleared flags
        base = cyc; fe("f_post", 4'b0000);
        ev("post_wb", 3, 5'b00100, MX_ALUWB, 4'b0000);
        run(4'b1110, 2'b00, 6'b101000, 4'd1, 4'b0000, 16'hFFFF, 4);

        // No-handshake instance: LDR in 5 cycles with mem_ready tied low
        reset_n = 1'b0;
        rst2_n = 1'b1;
        base = cyc;
        cond = 4'b1110; op = 2'b01; funct = 6'b011001; rd = 4'd1; alu_flags = 4'b0000;
        snap("nh_fetch", base + 0, 1'b1, 5'b11000, MX_FETCH, 4'b0000);
        snap("nh_memrd", base + 3, 1'b1, 5'b00000, MX_MEM, 4'b0000);
        snap("nh_memwb", base + 4, 1'b1, 5'b00100, MX_MEMWB, 4'b0000);
        snap("nh_next",  base + 5, 1'b1, 5'b11000, MX_FETCH, 4'b0000);
        repeat (6) @(posedge clk);
        #1 done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_finish: summary not reached, expected finish");
        $fatal(1, "monitor did not finish");
    end

endmodule
